// File: rtl/uart_rx_word.sv
// UART 8N1 receiver that packs four bytes into a 32-bit word.
// The first byte received is bits [7:0]. Reports framing errors and inter-byte timeouts.
module uart_rx_word #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_line,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam int BAUD_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam int TO_TICKS   = TIMEOUT_BITS * BAUD_TICKS;
    localparam int TW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
    localparam int IW = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_TICKS - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(HALF_TICKS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TO_TICKS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;
    logic [2:0]    r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic [2:0]    r_bit_idx;
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_shift;
    logic [31:0]   r_word_buf;
    logic          r_word_done;
    logic [31:0]   r_data_out;
    logic          r_data_valid;
    logic          r_frame_err;
    logic          r_timeout_err;

    assign w_rx_s      = r_sync2;
    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_err   = r_frame_err;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != S_IDLE) || (r_byte_idx != 2'd0);

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_line;
            r_sync2 <= r_sync1;
        end
    end

    // Bit-level FSM, byte assembly into the word buffer and timeout tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tick_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_bit_idx     <= '0;
            r_byte_idx    <= '0;
            r_shift       <= '0;
            r_word_buf    <= '0;
            r_word_done   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_word_done   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_idle_cnt    <= '0;
            unique case (r_state)
                S_IDLE: begin
                    r_tick_cnt <= '0;
                    if (!w_rx_s) begin
                        // A start edge wins over a timeout in the same cycle.
                        r_state <= S_START;
                    end else if (r_byte_idx != 2'd0) begin
                        if (r_idle_cnt == IDLE_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_byte_idx    <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (r_tick_cnt == TICK_HALF) begin
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        r_tick_cnt <= '0;
                        if (w_rx_s) begin
                            r_word_buf[{r_byte_idx, 3'b000} +: 8] <= r_shift;
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_word_done <= (r_byte_idx == 2'd3);
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_byte_idx  <= '0;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_tick_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Publish the completed word one cycle after its last stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= r_word_done;
            if (r_word_done) begin
                r_data_out <= r_word_buf;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 10 clocks per bit.
// Table of whole words plus hand sequences for glitch, framing, timeout and reset.
module tb_uart_rx_word;

    localparam int BT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_line = 1'b1;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        timeout_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_frame = 0;
    int n_to = 0;
    int n_overlap = 0;
    int t_to = 0;
    logic [31:0] vword[$];
    int vcyc[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    uart_rx_word #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_line    (rx_line),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid <= n_valid + 1;
            vword.push_back(data_out);
            vcyc.push_back(cyc);
        end
        if (frame_err) n_frame <= n_frame + 1;
        if (timeout_err) begin
            n_to <= n_to + 1;
            t_to <= cyc;
        end
        if (int'(data_valid) + int'(frame_err) + int'(timeout_err) > 1)
            n_overlap <= n_overlap + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BT) @(negedge clk);
        end
        rx_line = stop;
        repeat (BT) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    vec_t vecs[4];
    int nv, nf, nt, q0, tb2;

    initial begin
        vecs[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 30, 32'hDEADBEEF};
        vecs[1] = '{8'h01, 8'h02, 8'h04, 8'h80, 15, 32'h80040201};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 15, 32'h00000000};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 15, 32'hFFFFFFFF};

        rst_n = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_frame", {31'b0, frame_err}, 32'h0);
        chk("rst_timeout", {31'b0, timeout_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            nv = n_valid; nf = n_frame; nt = n_to;
            send_word(vecs[k].b0, vecs[k].b1, vecs[k].b2, vecs[k].b3);
            repeat (vecs[k].gap) @(negedge clk);
            chk($sformatf("vec%0d_valid_cnt", k), n_valid - nv, 1);
            chk($sformatf("vec%0d_data", k), data_out, vecs[k].exp);
            chk($sformatf("vec%0d_frame", k), n_frame - nf, 0);
            chk($sformatf("vec%0d_timeout", k), n_to - nt, 0);
            chk($sformatf("vec%0d_busy", k), {31'b0, busy}, 32'h0);
        end

        // Short low glitch must be rejected as a false start.
        nv = n_valid; nf = n_frame; nt = n_to;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy", {31'b0, busy}, 32'h0);
        chk("glitch_pulses", n_valid + n_frame + n_to - nv - nf - nt, 0);
        send_word(8'h67, 8'h45, 8'h23, 8'h01);
        repeat (10) @(negedge clk);
        chk("glitch_word_cnt", n_valid - nv, 1);
        chk("glitch_word", data_out, 32'h01234567);

        // Low stop bit followed by a held-low break.
        nv = n_valid; nf = n_frame; nt = n_to;
        send_byte(8'h55, 1'b0);
        repeat (50) @(negedge clk);
        chk("break_busy", {31'b0, busy}, 32'h1);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        chk("frame_cnt", n_frame - nf, 1);
        chk("frame_no_valid", n_valid - nv, 0);
        send_word(8'h0D, 8'hF0, 8'hFE, 8'hCA);
        repeat (10) @(negedge clk);
        chk("frame_word_cnt", n_valid - nv, 1);
        chk("frame_word", data_out, 32'hCAFEF00D);
        chk("frame_cnt_after", n_frame - nf, 1);

        // Partial word abandoned by the inter-byte timeout.
        nv = n_valid; nt = n_to;
        send_byte(8'h11, 1'b1);
        tb2 = cyc;
        send_byte(8'h22, 1'b1);
        chk("partial_busy", {31'b0, busy}, 32'h1);
        repeat (25 * BT) @(negedge clk);
        chk("timeout_cnt", n_to - nt, 1);
        chk("timeout_lat", t_to - tb2, 298);
        chk("timeout_no_valid", n_valid - nv, 0);
        chk("timeout_busy", {31'b0, busy}, 32'h0);
        send_word(8'h33, 8'h44, 8'h55, 8'h66);
        repeat (10) @(negedge clk);
        chk("timeout_word", data_out, 32'h66554433);
        chk("timeout_cnt_after", n_to - nt, 1);

        // Reset in the middle of the second byte.
        send_byte(8'h12, 1'b1);
        rx_line = 1'b0;
        repeat (BT) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * BT) @(negedge clk);
        nv = n_valid; nf = n_frame; nt = n_to;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_pulses",
            {29'b0, data_valid, frame_err, timeout_err}, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_word(8'h5A, 8'h5A, 8'hA5, 8'hA5);
        repeat (10) @(negedge clk);
        chk("rst_word_cnt", n_valid - nv, 1);
        chk("rst_word", data_out, 32'hA5A55A5A);
        chk("rst_no_err", n_frame + n_to - nf - nt, 0);

        // Three words with no idle time between frames.
        nv = n_valid;
        q0 = vword.size();
        send_word(8'hDF, 8'h9B, 8'h57, 8'h13);
        send_word(8'hE0, 8'hAC, 8'h68, 8'h24);
        send_word(8'h98, 8'hBA, 8'hDC, 8'hFE);
        repeat (10) @(negedge clk);
        chk("b2b_cnt", n_valid - nv, 3);
        if (vword.size() >= q0 + 3) begin
            chk("b2b_w0", vword[q0], 32'h13579BDF);
            chk("b2b_w1", vword[q0 + 1], 32'h2468ACE0);
            chk("b2b_w2", vword[q0 + 2], 32'hFEDCBA98);
            chk("b2b_gap1", vcyc[q0 + 1] - vcyc[q0], 400);
            chk("b2b_gap2", vcyc[q0 + 2] - vcyc[q0 + 1], 400);
        end
        chk("no_overlap", n_overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
